// File: rtl/debug_tx_scheduler.sv
// debug_tx_scheduler: arbitrates snapshot frames and command-response packets onto
// the usb_serial debug TX byte channel. Packets never interleave, the two requesters
// alternate round-robin on a tie, and accepted bytes are spaced by GAP_CYCLES idle cycles.
module debug_tx_scheduler #(
    parameter int          NUM_BYTES  = 8,
    parameter int          GAP_CYCLES = 4096,
    parameter logic [7:0]  FRAME_HDR  = 8'hFF,
    parameter logic [7:0]  RSP_HDR    = 8'hFE
) (
    input  logic                   clk_48mhz,
    input  logic                   resetn,
    input  logic                   frame_req,
    input  logic [NUM_BYTES*8-1:0] snap_data,
    input  logic                   rsp_valid,
    input  logic [7:0]             rsp_data,
    input  logic                   rsp_last,
    output logic                   rsp_ready,
    output logic                   out_valid,
    output logic [7:0]             out_data,
    input  logic                   out_ready,
    output logic                   busy,
    output logic [7:0]             frames_dropped
);

    localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES);
    localparam logic [GAP_W-1:0] GAP_ZERO = GAP_W'(0);
    localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);
    localparam logic [3:0]       IDX_LAST = 4'(NUM_BYTES - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_F_HDR  = 3'd1,
        ST_F_DATA = 3'd2,
        ST_R_HDR  = 3'd3,
        ST_R_DATA = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [GAP_W-1:0]   r_gap_cnt;
    logic               r_frame_pend;
    logic               r_last_rsp;     // 1: last grant went to the response stream
    logic [127:0]       r_snap;         // zero-padded so any 4-bit index selects in range
    logic [3:0]         r_idx;
    logic [7:0]         r_drop_cnt;

    logic               w_gap_ok;
    logic               w_idle;
    logic               w_xfer;
    logic               w_frame_grant;
    logic               w_rsp_grant;

    assign w_gap_ok      = (r_gap_cnt == GAP_ZERO);
    assign w_idle        = (r_state == ST_IDLE);
    assign w_xfer        = out_valid & out_ready;
    // A tie goes to whichever requester was not served last.
    assign w_frame_grant = w_idle & w_gap_ok & r_frame_pend & (~rsp_valid | r_last_rsp);
    assign w_rsp_grant   = w_idle & w_gap_ok & rsp_valid & (~r_frame_pend | ~r_last_rsp);
    assign busy           = (r_state != ST_IDLE);
    assign frames_dropped = r_drop_cnt;

    // State register.
    always_ff @(posedge clk_48mhz) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode: grants leave IDLE, completed transfers walk through the packet.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_frame_grant) begin
                    w_state_next = ST_F_HDR;
                end else if (w_rsp_grant) begin
                    w_state_next = ST_R_HDR;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_F_HDR: begin
                if (w_xfer) w_state_next = ST_F_DATA;
                else        w_state_next = ST_F_HDR;
            end
            ST_F_DATA: begin
                if (w_xfer && (r_idx == IDX_LAST)) w_state_next = ST_IDLE;
                else                               w_state_next = ST_F_DATA;
            end
            ST_R_HDR: begin
                if (w_xfer) w_state_next = ST_R_DATA;
                else        w_state_next = ST_R_HDR;
            end
            ST_R_DATA: begin
                if (w_xfer && rsp_last) w_state_next = ST_IDLE;
                else                    w_state_next = ST_R_DATA;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Output decode; the response body is passed straight through, gated by the pacing gap.
    always_comb begin
        out_valid = 1'b0;
        out_data  = 8'h00;
        rsp_ready = 1'b0;
        case (r_state)
            ST_IDLE: begin
                out_valid = 1'b0;
            end
            ST_F_HDR: begin
                out_valid = w_gap_ok;
                out_data  = FRAME_HDR;
            end
            ST_F_DATA: begin
                out_valid = w_gap_ok;
                out_data  = r_snap[{r_idx, 3'b000} +: 8];
            end
            ST_R_HDR: begin
                out_valid = w_gap_ok;
                out_data  = RSP_HDR;
            end
            ST_R_DATA: begin
                out_valid = rsp_valid & w_gap_ok;
                out_data  = rsp_data;
                rsp_ready = out_ready & w_gap_ok;
            end
            default: begin
                out_valid = 1'b0;
            end
        endcase
    end

    // Inter-byte gap: reload on every accepted byte, otherwise count down to zero.
    always_ff @(posedge clk_48mhz) begin
        if (!resetn) begin
            r_gap_cnt <= GAP_ZERO;
        end else if (w_xfer) begin
            r_gap_cnt <= GAP_LOAD;
        end else if (r_gap_cnt != GAP_ZERO) begin
            r_gap_cnt <= r_gap_cnt - GAP_ONE;
        end else begin
            r_gap_cnt <= r_gap_cnt;
        end
    end

    // Frame request latch, round-robin memory and saturating drop counter.
    always_ff @(posedge clk_48mhz) begin
        if (!resetn) begin
            r_frame_pend <= 1'b0;
            r_last_rsp   <= 1'b1;
            r_drop_cnt   <= 8'h00;
        end else begin
            r_frame_pend <= frame_req | (r_frame_pend & ~w_frame_grant);
            if (w_frame_grant) begin
                r_last_rsp <= 1'b0;
            end else if (w_rsp_grant) begin
                r_last_rsp <= 1'b1;
            end else begin
                r_last_rsp <= r_last_rsp;
            end
            if (frame_req && r_frame_pend && !w_frame_grant && (r_drop_cnt != 8'hFF)) begin
                r_drop_cnt <= r_drop_cnt + 8'd1;
            end else begin
                r_drop_cnt <= r_drop_cnt;
            end
        end
    end

    // Snapshot capture at frame grant and byte index within the frame body.
    always_ff @(posedge clk_48mhz) begin
        if (!resetn) begin
            r_snap <= 128'h0;
            r_idx  <= 4'd0;
        end else if (w_frame_grant) begin
            r_snap <= 128'(snap_data);
            r_idx  <= 4'd0;
        end else if ((r_state == ST_F_DATA) && w_xfer) begin
            r_snap <= r_snap;
            r_idx  <= r_idx + 4'd1;
        end else begin
            r_snap <= r_snap;
            r_idx  <= r_idx;
        end
    end

endmodule

// File: tb/tb_debug_tx_scheduler.sv
// Randomized bench for debug_tx_scheduler. A timestamp-based reference model
// (last transfer time, last frame request, last frame grant) predicts every output
// each cycle; a second GAP=0 instance checks back-to-back frame emission.
module tb_debug_tx_scheduler;

    localparam int NB  = 8;
    localparam int GAP = 3;

    logic           clk_48mhz = 1'b0;
    logic           resetn;
    logic           frame_req;
    logic [NB*8-1:0] snap_data;
    logic           rsp_valid;
    logic [7:0]     rsp_data;
    logic           rsp_last;
    logic           rsp_ready;
    logic           out_valid;
    logic [7:0]     out_data;
    logic           out_ready;
    logic           busy;
    logic [7:0]     frames_dropped;

    logic           z_frame_req;
    logic           z_rsp_ready;
    logic           z_out_valid;
    logic [7:0]     z_out_data;
    logic           z_busy;
    logic [7:0]     z_frames_dropped;
    logic [NB*8-1:0] z_snap = 64'h0706050403020100;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;

    // reference model state
    int          kind;          // 0 none, 1 frame, 2 response
    int          pos;           // 0 = header, then body bytes
    int          last_kind;
    int          last_x;
    int          last_req;
    int          last_fgrant;
    int          drops;
    int          gk;
    bit          gap_ok, pend, ev, er, xfer;
    logic [7:0]  ed;
    logic [7:0]  exp_snap [NB];
    logic [8:0]  rq [$];        // {last, data} bytes waiting at the response source
    bit          rsp_hold;
    bit          did_rst;
    int          rdy_cnt;
    bit          prev_busy;
    logic [7:0]  prev_hdr;
    bit          have_hdr;
    int          zt;

    always #10 clk_48mhz = ~clk_48mhz;

    debug_tx_scheduler #(.NUM_BYTES(NB), .GAP_CYCLES(GAP)) dut (
        .clk_48mhz(clk_48mhz), .resetn(resetn), .frame_req(frame_req), .snap_data(snap_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_last(rsp_last), .rsp_ready(rsp_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready), .busy(busy),
        .frames_dropped(frames_dropped)
    );

    debug_tx_scheduler #(.NUM_BYTES(NB), .GAP_CYCLES(0)) dut_z (
        .clk_48mhz(clk_48mhz), .resetn(resetn), .frame_req(z_frame_req), .snap_data(z_snap),
        .rsp_valid(1'b0), .rsp_data(8'h00), .rsp_last(1'b0), .rsp_ready(z_rsp_ready),
        .out_valid(z_out_valid), .out_data(z_out_data), .out_ready(1'b1), .busy(z_busy),
        .frames_dropped(z_frames_dropped)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic gen_packet();
        int len;
        len = $urandom_range(1, 4);
        for (int i = 0; i < len; i++) begin
            rq.push_back({(i == len - 1) ? 1'b1 : 1'b0, 8'($urandom)});
        end
    endtask

    task automatic model_reset();
        kind = 0; pos = 0; last_kind = 2; last_x = -1000;
        last_req = -2; last_fgrant = -1; drops = 0;
    endtask

    initial begin
        resetn = 1'b0; frame_req = 1'b0; z_frame_req = 1'b0; snap_data = 64'h0;
        rsp_valid = 1'b0; rsp_data = 8'h00; rsp_last = 1'b0; out_ready = 1'b1;
        rsp_hold = 1'b0; did_rst = 1'b0; rdy_cnt = 0; prev_busy = 1'b0; have_hdr = 1'b0;
        prev_hdr = 8'h00;
        model_reset();
        repeat (3) @(posedge clk_48mhz);
        @(negedge clk_48mhz);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_rsp_ready", 32'(rsp_ready), 32'd0);
        check_eq("rst_dropped", 32'(frames_dropped), 32'd0);
        check_eq("rst_z_valid", 32'(z_out_valid), 32'd0);

        for (cyc = 0; cyc < 2500; cyc++) begin
            @(posedge clk_48mhz);
            #1;
            // ---------------- stimulus ----------------
            resetn = 1'b1;
            frame_req = 1'b0;
            z_frame_req = (cyc == 2);
            if (cyc < 80) begin
                out_ready = 1'b1;
                frame_req = (cyc == 3);
                if (cyc == 4) begin
                    rq.push_back({1'b0, 8'hAA});
                    rq.push_back({1'b1, 8'hBB});
                end
                if (rq.size() > 0) rsp_hold = 1'b1;
            end else if (cyc < 1080) begin
                out_ready = ($urandom_range(0, 3) != 0);
                frame_req = ($urandom_range(0, 39) == 0);
                if ($urandom_range(0, 3) == 0) snap_data = {$urandom, $urandom};
                if (rq.size() == 0 && $urandom_range(0, 19) == 0) gen_packet();
                if (!rsp_hold && rq.size() > 0 && $urandom_range(0, 1) == 0) rsp_hold = 1'b1;
                if (!did_rst && kind == 1 && pos == 3) begin
                    resetn = 1'b0;
                    did_rst = 1'b1;
                end
            end else if (cyc < 1480) begin
                out_ready = 1'b0;
                frame_req = 1'b1;
            end else begin
                out_ready = 1'b1;
                frame_req = 1'b1;
                if ($urandom_range(0, 1) == 0) snap_data = {$urandom, $urandom};
                if (rq.size() < 2) gen_packet();
                if (rq.size() > 0) rsp_hold = 1'b1;
            end
            if (!resetn) begin
                frame_req = 1'b0;
                rq.delete();
                rsp_hold = 1'b0;
            end
            rsp_valid = rsp_hold;
            if (rsp_hold) {rsp_last, rsp_data} = rq[0];
            else          {rsp_last, rsp_data} = 9'($urandom);

            @(negedge clk_48mhz);
            // ---------------- GAP=0 instance: back-to-back frame ----------------
            if (cyc >= 2 && cyc <= 13) begin
                zt = cyc - 2;
                check_eq("z_valid", 32'(z_out_valid), (zt >= 2 && zt <= 10) ? 32'd1 : 32'd0);
                if (zt >= 2 && zt <= 10)
                    check_eq("z_data", 32'(z_out_data), (zt == 2) ? 32'hFF : 32'(zt - 3));
                if (zt == 11) check_eq("z_busy_end", 32'(z_busy), 32'd0);
            end
            // ---------------- reference model ----------------
            if (!resetn) begin
                model_reset();
            end else begin
                gap_ok = ((cyc - last_x) > GAP);
                pend   = (last_req >= last_fgrant);
                ev = 1'b0; er = 1'b0; ed = 8'h00; gk = 0;
                case (kind)
                    0: if (gap_ok && (pend || rsp_valid))
                           gk = (pend && (!rsp_valid || last_kind == 2)) ? 1 : 2;
                    1: begin
                        ev = gap_ok;
                        ed = (pos == 0) ? 8'hFF : exp_snap[pos-1];
                    end
                    2: begin
                        if (pos == 0) begin
                            ev = gap_ok;
                            ed = 8'hFE;
                        end else begin
                            ev = rsp_valid && gap_ok;
                            ed = rsp_data;
                            er = out_ready && gap_ok;
                        end
                    end
                    default: ;
                endcase
                check_eq("out_valid", 32'(out_valid), 32'(ev));
                if (ev) check_eq("out_data", 32'(out_data), 32'(ed));
                check_eq("rsp_ready", 32'(rsp_ready), 32'(er));
                check_eq("busy", 32'(busy), (kind != 0) ? 32'd1 : 32'd0);
                check_eq("frames_dropped", 32'(frames_dropped), 32'(drops));

                xfer = ev && out_ready;
                if (xfer) begin
                    last_x = cyc;
                    if (kind == 2 && pos > 0) begin
                        rq.delete(0);
                        rsp_hold = 1'b0;
                        if (rsp_last) kind = 0;
                    end else if (kind == 1 && pos == NB) begin
                        kind = 0;
                    end
                    pos++;
                end
                if (frame_req && pend && gk != 1 && drops < 255) drops++;
                if (frame_req) last_req = cyc;
                if (gk != 0) begin
                    kind = gk; pos = 0; last_kind = gk;
                    if (gk == 1) begin
                        last_fgrant = cyc;
                        for (int i = 0; i < NB; i++) exp_snap[i] = snap_data[i*8 +: 8];
                    end
                end
            end
            // ---------------- directed phase checks ----------------
            if (cyc < 80 && rsp_ready) rdy_cnt++;
            if (cyc == 79) check_eq("t2_rsp_ready_pulses", 32'(rdy_cnt), 32'd2);
            if (cyc == 1479) check_eq("drop_saturate", 32'(frames_dropped), 32'd255);
            if (cyc >= 1480 && busy && !prev_busy) begin
                check_eq("t6_hdr_valid", 32'(out_valid), 32'd1);
                if (have_hdr) check_eq("t6_alternate", (out_data != prev_hdr) ? 32'd1 : 32'd0, 32'd1);
                prev_hdr = out_data;
                have_hdr = 1'b1;
            end
            prev_busy = busy;
        end
        check_eq("t6_seen_packets", 32'(have_hdr), 32'd1);
        check_eq("mid_frame_reset_hit", 32'(did_rst), 32'd1);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
